// File: rtl/cordic_abs_fold.sv
// Folds a signed (x, y) pair into the first quadrant with saturating magnitudes, behind a 2-entry skid buffer.
// Define CORDIC_ABS_OCTANT_SWAP_EN to also exchange x/y so that x_out >= y_out (octant-0 fold).
module cordic_abs_fold #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  x_neg,
    output logic                  y_neg,
    output logic                  sat,
    output logic                  swap,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam int RW = 2 * DATA_WIDTH + 4 + TAG_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MIN_C = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_C = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Returns {sat, neg, mag}; the most-negative code has no positive twin, so it clamps.
    function automatic logic [DATA_WIDTH+1:0] fold_abs(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] mag;
        logic                  clamp;
        if (v == MIN_C) begin
            mag   = MAX_C;
            clamp = 1'b1;
        end else if (v[DATA_WIDTH-1]) begin
            mag   = {DATA_WIDTH{1'b0}} - v;
            clamp = 1'b0;
        end else begin
            mag   = v;
            clamp = 1'b0;
        end
        return {clamp, v[DATA_WIDTH-1], mag};
    endfunction

    state_t                state_r;
    logic [RW-1:0]         main_r;
    logic [RW-1:0]         skid_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic [DATA_WIDTH+1:0] x_f_s;
    logic [DATA_WIDTH+1:0] y_f_s;
    logic [DATA_WIDTH-1:0] x_mag_s;
    logic [DATA_WIDTH-1:0] y_mag_s;
    logic                  swap_s;
    logic [RW-1:0]         result_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    // Fold the incoming pair and pack it into one result word.
    always_comb begin
        x_f_s   = fold_abs(x_in);
        y_f_s   = fold_abs(y_in);
        x_mag_s = x_f_s[DATA_WIDTH-1:0];
        y_mag_s = y_f_s[DATA_WIDTH-1:0];
        swap_s  = 1'b0;
`ifdef CORDIC_ABS_OCTANT_SWAP_EN
        if (y_f_s[DATA_WIDTH-1:0] > x_f_s[DATA_WIDTH-1:0]) begin
            x_mag_s = y_f_s[DATA_WIDTH-1:0];
            y_mag_s = x_f_s[DATA_WIDTH-1:0];
            swap_s  = 1'b1;
        end else begin
            swap_s  = 1'b0;
        end
`endif
        result_s = {x_mag_s, y_mag_s, x_f_s[DATA_WIDTH], y_f_s[DATA_WIDTH],
                    x_f_s[DATA_WIDTH+1] | y_f_s[DATA_WIDTH+1], swap_s, tag_in};
    end

    // Skid-buffer control; in_ready_r is registered so it never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            main_r      <= {RW{1'b0}};
            skid_r      <= {RW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_r      <= result_s;
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                    in_ready_r <= 1'b1;
                end
                ONE: begin
                    if (in_xfer_s && !out_xfer_s) begin
                        skid_r     <= result_s;
                        state_r    <= TWO;
                        in_ready_r <= 1'b0;
                    end else if (out_xfer_s && !in_xfer_s) begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else if (in_xfer_s) begin
                        main_r     <= result_s;
                        in_ready_r <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                TWO: begin
                    if (out_xfer_s) begin
                        main_r     <= skid_r;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign x_out     = main_r[RW-1 -: DATA_WIDTH];
    assign y_out     = main_r[RW-DATA_WIDTH-1 -: DATA_WIDTH];
    assign x_neg     = main_r[TAG_WIDTH+3];
    assign y_neg     = main_r[TAG_WIDTH+2];
    assign sat       = main_r[TAG_WIDTH+1];
    assign swap      = main_r[TAG_WIDTH];
    assign tag_out   = main_r[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_cordic_abs_fold.sv
// Directed bench for cordic_abs_fold: vector table plus back-pressure, throughput and reset sequences.
module tb_cordic_abs_fold;

`ifdef CORDIC_ABS_OCTANT_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = 16'd0;
    logic [15:0] y_in = 16'd0;
    logic [3:0]  tag_in = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic        x_neg;
    logic        y_neg;
    logic        sat;
    logic        swap;
    logic [3:0]  tag_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  tag;
        logic [15:0] ex;
        logic [15:0] ey;
        logic        exn;
        logic        eyn;
        logic        esat;
    } vec_t;

    vec_t vecs[9];

    cordic_abs_fold #(.DATA_WIDTH(16), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .x_neg(x_neg),
        .y_neg(y_neg), .sat(sat), .swap(swap), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [3:0] t);
        in_valid = v;
        x_in     = x;
        y_in     = y;
        tag_in   = t;
    endtask

    // Expected packed {x_out, y_out, x_neg, y_neg, sat, swap, tag_out} from unswapped magnitudes.
    function automatic logic [39:0] expect_of(input logic [15:0] ex, input logic [15:0] ey,
                                             input logic exn, input logic eyn, input logic esat,
                                             input logic [3:0] t);
        if (SWAP_EN && (ey > ex)) return {ey, ex, exn, eyn, esat, 1'b1, t};
        return {ex, ey, exn, eyn, esat, 1'b0, t};
    endfunction

    function automatic logic [39:0] actual();
        return {x_out, y_out, x_neg, y_neg, sat, swap, tag_out};
    endfunction

    function automatic logic [15:0] mag16(input logic [15:0] v);
        if (v == 16'h8000) return 16'h7FFF;
        if (v[15]) return 16'd0 - v;
        return v;
    endfunction

    initial begin
        logic [15:0] xh;
        int sent;
        int got;
        logic acc_in;
        logic acc_out;

        vecs[0] = '{16'hFFFB, 16'h0003, 4'd2, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'h8000, 16'h0000, 4'd3, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0000, 16'h8000, 4'd4, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 4'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h8001, 4'd6, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0002, 16'hFFF7, 4'd7, 16'h0002, 16'h0009, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h0007, 16'h0007, 4'd8, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0001, 4'd9, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 4'd10, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1};

        // Reset state
        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_outputs", actual(), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", in_ready, 1'b1);

        // Single pair, out_valid for exactly one cycle
        drive(1'b1, vecs[0].x, vecs[0].y, vecs[0].tag);
        step();
        drive(1'b0, 16'd0, 16'd0, 4'd0);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", actual(), expect_of(vecs[0].ex, vecs[0].ey, vecs[0].exn, vecs[0].eyn, vecs[0].esat, vecs[0].tag));
        step();
        chk("single_valid_drop", out_valid, 1'b0);

        // Table, back-to-back
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].tag);
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_data", i), actual(),
                expect_of(vecs[i].ex, vecs[i].ey, vecs[i].exn, vecs[i].eyn, vecs[i].esat, vecs[i].tag));
        end
        drive(1'b0, 16'd0, 16'd0, 4'd0);
        step();

        // Full throughput: 16 pairs, 1-cycle latency, in_ready held high
        for (int i = 0; i < 16; i++) begin
            logic [15:0] xv;
            logic [15:0] yv;
            xv = 16'(i * 37 - 300);
            yv = 16'(500 - i * 61);
            drive(1'b1, xv, yv, 4'(i));
            step();
            chk($sformatf("tput%0d", i), {out_valid, in_ready, actual()},
                {1'b1, 1'b1, expect_of(mag16(xv), mag16(yv), xv[15], yv[15], 1'b0, 4'(i))});
        end
        drive(1'b0, 16'd0, 16'd0, 4'd0);
        step();
        chk("tput_drain", out_valid, 1'b0);

        // Back-pressure: tags 0..5 with out_ready low
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 16'd0 - 16'((sent + 1) * 3), 16'(sent), 4'(sent));
            acc_in = in_ready;
            step();
            if (acc_in) sent++;
        end
        chk("bp_accepted", 64'(sent), 64'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head", {out_valid, tag_out}, {1'b1, 4'd0});
        xh = x_out;
        step();
        chk("bp_stable", x_out, xh);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (sent < 6) drive(1'b1, 16'd0 - 16'((sent + 1) * 3), 16'(sent), 4'(sent));
            else drive(1'b0, 16'd0, 16'd0, 4'd0);
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                chk($sformatf("bp_order%0d", got), {tag_out, x_out}, {4'(got), 16'((got + 1) * 3)});
                got++;
            end
            step();
            if (acc_in) sent++;
        end
        chk("bp_all_out", 64'(got), 64'd6);
        drive(1'b0, 16'd0, 16'd0, 4'd0);
        chk("bp_no_dup", out_valid, 1'b0);

        // Reset while two entries are held
        out_ready = 1'b0;
        drive(1'b1, 16'd11, 16'd12, 4'd1);
        step();
        drive(1'b1, 16'd13, 16'd14, 4'd2);
        step();
        drive(1'b0, 16'd0, 16'd0, 4'd0);
        chk("two_in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {out_valid, actual()}, 41'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(1'b1, 16'd10, 16'hFFEC, 4'd5);
        step();
        drive(1'b0, 16'd0, 16'd0, 4'd0);
        chk("postrst_pair", {out_valid, actual()}, {1'b1, expect_of(16'd10, 16'd20, 1'b0, 1'b1, 1'b0, 4'd5)});
        step();
        chk("postrst_only_one", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
